mult_control: RTL and testbench
===============================

Name: mult_control

Overview:
- Sequencing FSM for the 8-bit shift-add signed multiplier.
- Drives the add/subtract unit (9-bit adder with sign-extended operands, fn select, M gate) and the A/X/B register shift chain.
- Runs N_BITS add-then-shift iterations, one run per Run assertion.
- The final iteration subtracts when the multiplier sign bit is 1.
- Sits between the top level (debounced, synchronous switch inputs) and the datapath registers.

Parameters:
- N_BITS, 8, number of add/shift iterations (multiplier width).
- CNT_W, $clog2(N_BITS+1), width of the iteration counter (derived; not overridden).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Run  input  1  level; start a multiply. Already synchronized.
- ClearA_LoadB  input  1  level; clear A/X and load B from switches.
- M  input  1  current LSB of the B register.
- clr_ax  output  1  synchronous clear of A and X registers.
- ld_b  output  1  load B from switches.
- ld_ax  output  1  load A[7:0] and X from the adder result S[8:0].
- fn  output  1  adder function: 0 = add, 1 = subtract.
- shift_en  output  1  arithmetic right shift of the X:A:B chain by one.
- busy  output  1  a multiply is in progress.
- done  output  1  result valid; held until Run is released.

Behaviour:
- States (enum):
  - IDLE
  - CLEAR
  - ADD
  - SHIFT
  - HOLD
- Iteration counter cnt (CNT_W bits).
- Async reset (Reset_n=0): state=IDLE, cnt=0. Every output is 0 during reset and in the cycle after release while in IDLE with both inputs low.
- IDLE:
  - ClearA_LoadB=1: ld_b=1 and clr_ax=1 this cycle; stay in IDLE. Has priority over Run.
  - Else Run=1: go to CLEAR.
- CLEAR: clr_ax=1, busy=1, cnt<=0; next state ADD.
- ADD:
  - busy=1.
  - ld_ax = M (Mealy, combinational on M).
  - fn = 1 iff cnt==N_BITS-1; otherwise fn=0. fn is also driven when M=0 (don't-care for the datapath, but deterministic).
  - Next state SHIFT.
- SHIFT:
  - shift_en=1, busy=1, cnt<=cnt+1.
  - If cnt==N_BITS-1 (pre-increment value), next state is HOLD; otherwise ADD.
- HOLD:
  - done=1, busy=0.
  - Stay while Run=1; go to IDLE when Run=0.
  - This gives exactly one multiply per Run assertion.
- Latency: CLEAR to first HOLD cycle is 1 + 2*N_BITS cycles, i.e. 17 for the default. done is asserted on cycle 18 after Run is sampled high in IDLE.
- Strobe exclusivity: clr_ax, ld_ax and shift_en are never high in the same cycle. ld_b is high only in IDLE.
- ClearA_LoadB is ignored in CLEAR/ADD/SHIFT/HOLD; a multiply in progress is never disturbed.
- Run deasserted mid-operation: the multiply completes; HOLD is entered and exits to IDLE on the next cycle.
- Reset mid-operation: immediate return to IDLE, cnt=0, all strobes low. The datapath partial result is not cleaned by this block.
- cnt never exceeds N_BITS-1 while in ADD/SHIFT; no wrap-around is possible.
- All state and counter registers update on the rising Clk edge only (apart from the async reset).

Decomposition:
- Package mult_ctrl_pkg holds:
  - state typedef (enum logic [2:0] with the states above)
  - default N_BITS constant
- One module with no sub-modules. The counter is inline; it is too small to justify its own block.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with Run=1 and ClearA_LoadB=1 → all outputs 0; release with both inputs low → state IDLE, outputs 0.
- ClearA_LoadB=1 for 1 cycle in IDLE → ld_b=1 and clr_ax=1 in that cycle only. Repeat with Run=1 simultaneously → same response, no CLEAR entry.
- Run=1 held for 30 cycles, M driven from a model of B=0x81 → clr_ax on cycle 1, then 8 ADD/SHIFT pairs:
  - ld_ax=1 on iteration 0 with fn=0.
  - ld_ax=1 on iteration 7 with fn=1.
  - ld_ax=0 on iterations 1-6.
  - 8 shift_en pulses total.
  - done from cycle 18 until Run drops; exactly one multiply.
- ClearA_LoadB pulsed on cycle 5 of a run → no ld_b/clr_ax response; run completes unchanged.
- Run pulsed for 1 cycle only → full 17-cycle sequence; done high for 1 cycle; back to IDLE.
- Reset_n pulsed low at iteration 4 → outputs 0 asynchronously, IDLE. A new Run then restarts from CLEAR with cnt=0 and again gives 8 shifts.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// ============================================================================
// mult_ctrl_pkg : shared types and defaults for the shift-add multiplier control
// Revision 1.0
// ============================================================================
`default_nettype none

package mult_ctrl_pkg;

  localparam int N_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_control.sv
// ============================================================================
// mult_control : sequencing FSM for the 8-bit shift-add signed multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

module mult_control
  import mult_ctrl_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic clr_ax,
  output logic ld_b,
  output logic ld_ax,
  output logic fn,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_iter;

  assign last_iter = (cnt_q == LAST_ITER);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!ClearA_LoadB && Run) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: state_d = SHIFT;
      SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = last_iter ? HOLD : ADD;
      end
      HOLD: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by Reset_n so an asserted reset forces every strobe low,
  // even the IDLE-state ClearA_LoadB response.
  always_comb begin
    clr_ax   = 1'b0;
    ld_b     = 1'b0;
    ld_ax    = 1'b0;
    fn       = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (Reset_n) begin
      case (state_q)
        IDLE: begin
          ld_b   = ClearA_LoadB;
          clr_ax = ClearA_LoadB;
        end
        CLEAR: begin
          clr_ax = 1'b1;
          busy   = 1'b1;
        end
        ADD: begin
          busy  = 1'b1;
          ld_ax = M;
          fn    = last_iter;
        end
        SHIFT: begin
          shift_en = 1'b1;
          busy     = 1'b1;
        end
        HOLD:    done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_control.sv
// ============================================================================
// tb_mult_control : directed self-checking bench for mult_control
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M = 1'b0;
  logic clr_ax, ld_b, ld_ax, fn, shift_en, busy, done;

  int n_checks = 0;
  int n_err    = 0;

  mult_control dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .clr_ax       (clr_ax),
    .ld_b         (ld_b),
    .ld_ax        (ld_ax),
    .fn           (fn),
    .shift_en     (shift_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 Clk = ~Clk;

  // Output vector order: {clr_ax, ld_b, ld_ax, fn, shift_en, busy, done}
  function automatic logic [6:0] outs();
    return {clr_ax, ld_b, ld_ax, fn, shift_en, busy, done};
  endfunction

  task automatic check_v(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One multiply: Run raised in IDLE (cycle 0), held through cycle run_len-1.
  // ClearA_LoadB pulsed in cycle clab_at. Expected outputs from a cycle model.
  task automatic mult_run(input string tag, input int ncyc, input int run_len,
                          input int clab_at, input logic [7:0] b);
    logic [6:0] exp;
    logic       hold_prev;
    logic       hold;
    int         it;
    int         shifts;
    int         dones;
    hold_prev = 1'b0;
    shifts    = 0;
    dones     = 0;
    @(posedge Clk); #1;
    Run = 1'b1;
    ClearA_LoadB = 1'b0;
    M = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge Clk); #1;
      Run          = (k < run_len);
      ClearA_LoadB = (k == clab_at);
      it           = (k >= 2 && k <= 17) ? (k - 2) / 2 : 0;
      M            = b[it];
      @(negedge Clk);
      exp = 7'b0;
      if (k == 1) begin
        exp = 7'b1000010;
        hold = 1'b0;
      end else if (k <= 17) begin
        if (k % 2 == 0) exp = {2'b00, b[it], (it == 7), 3'b010};
        else            exp = 7'b0000110;
        hold = 1'b0;
      end else begin
        hold = (k == 18) ? 1'b1 : (hold_prev && ((k - 1) < run_len));
        exp  = {6'b0, hold};
      end
      hold_prev = hold;
      if (shift_en) shifts++;
      if (done) dones++;
      check_v($sformatf("%s cyc%0d", tag, k), outs(), exp);
    end
    check_i({tag, " shift_count"}, shifts, 8);
    check_i({tag, " done_count"}, dones, (run_len > 18) ? run_len - 17 : 1);
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    M = 1'b0;
  endtask

  initial begin
    // Reset held with both inputs high: all outputs must stay low.
    Reset_n = 1'b0;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_v($sformatf("reset_hold%0d", i), outs(), 7'b0);
    end
    @(posedge Clk); #1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);
    check_v("reset_release", outs(), 7'b0);
    @(negedge Clk);
    check_v("idle_after_reset", outs(), 7'b0);

    // ClearA_LoadB in IDLE: single-cycle ld_b + clr_ax.
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    check_v("clab_idle", outs(), 7'b1100000);
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    check_v("clab_idle_off", outs(), 7'b0);

    // Same with Run high: ClearA_LoadB wins, no CLEAR entry.
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    @(negedge Clk);
    check_v("clab_run", outs(), 7'b1100000);
    @(posedge Clk); #1;
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    @(negedge Clk);
    check_v("clab_run_no_clear", outs(), 7'b0);
    @(negedge Clk);
    check_v("clab_run_idle", outs(), 7'b0);

    // Full multiply with B=0x81, Run held 30 cycles.
    mult_run("run81", 33, 31, -1, 8'h81);
    @(negedge Clk);
    check_v("run81_idle", outs(), 7'b0);

    // ClearA_LoadB pulsed mid-run is ignored.
    mult_run("clab_mid", 22, 20, 5, 8'h81);

    // Run pulsed for a single cycle, different multiplier pattern.
    mult_run("pulse", 20, 1, -1, 8'h5A);

    // Reset during iteration 4 (ADD cycle 10).
    @(posedge Clk); #1;
    Run = 1'b1;
    M = 1'b1;
    for (int i = 0; i < 10; i++) @(posedge Clk);
    #2;
    check_v("pre_reset_add", outs(), 7'b0010010);
    Reset_n = 1'b0;
    #1;
    check_v("async_reset", outs(), 7'b0);
    @(posedge Clk); #1;
    Run = 1'b0;
    M = 1'b0;
    @(negedge Clk);
    check_v("reset_mid_hold", outs(), 7'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    check_v("reset_mid_idle", outs(), 7'b0);

    // Restart after reset must begin at CLEAR with cnt=0.
    mult_run("restart", 20, 2, -1, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
